// File: rtl/conv_5_mul_share_arb.sv
// rtl/conv_5_mul_share_arb.sv - round-robin shared signed 16x8 multiplier for conv_5 tap engines
// Grants one operand pair per cycle; results return tagged to the originating requester.
module conv_5_mul_share_arb #(
    parameter int N_REQ      = 4,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 24
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic                          arb_en,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*din0_WIDTH-1:0]   req_din0,
    input  logic [N_REQ*din1_WIDTH-1:0]   req_din1,
    output logic [N_REQ-1:0]              rsp_vld,
    output logic [N_REQ*dout_WIDTH-1:0]   rsp_dout,
    output logic                          busy
);
    localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [TW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]           gnt_idx;
    logic                    found;
    logic                    xfer;
    int                      idx;
    logic [din0_WIDTH-1:0]   a_sel;
    logic [din1_WIDTH-1:0]   b_sel;

    logic                    fin_vld;
    logic [TW-1:0]           fin_tag;
    logic [dout_WIDTH-1:0]   fin_prod;

    logic [N_REQ-1:0]            rsp_vld_q, rsp_vld_d;
    logic [N_REQ*dout_WIDTH-1:0] rsp_dout_q, rsp_dout_d;

    function automatic logic [dout_WIDTH-1:0] mul(input logic signed [din0_WIDTH-1:0] a,
                                                  input logic signed [din1_WIDTH-1:0] b);
        logic signed [dout_WIDTH-1:0] ae;
        logic signed [dout_WIDTH-1:0] be;
        ae = dout_WIDTH'(a);
        be = dout_WIDTH'(b);
        return ae * be;
    endfunction

    // Search from rr_ptr with wrap; grant depends only on valids, never on operand data.
    always_comb begin
        found     = 1'b0;
        gnt_idx   = rr_ptr_q;
        idx       = 0;
        req_ready = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = TW'(idx);
            end
        end
        if (found && arb_en && !ap_rst) req_ready[gnt_idx] = 1'b1;
    end

    assign xfer  = |(req_valid & req_ready);
    assign a_sel = req_din0[int'(gnt_idx)*din0_WIDTH +: din0_WIDTH];
    assign b_sel = req_din1[int'(gnt_idx)*din1_WIDTH +: din1_WIDTH];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) rr_ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end

    if (NUM_STAGE == 1) begin : g_comb
        assign fin_vld  = xfer;
        assign fin_tag  = gnt_idx;
        assign fin_prod = mul(a_sel, b_sel);
        assign busy     = 1'b0;
    end else begin : g_pipe
        localparam int D = NUM_STAGE - 1;

        logic [D-1:0]          vld_q, vld_d;
        logic [TW-1:0]         tag_q [D];
        logic [TW-1:0]         tag_d [D];
        logic [din0_WIDTH-1:0] a_q, a_d;
        logic [din1_WIDTH-1:0] b_q, b_d;
        logic [dout_WIDTH-1:0] mult;

        always_comb begin
            vld_d[0] = xfer;
            tag_d[0] = gnt_idx;
            a_d      = a_sel;
            b_d      = b_sel;
            for (int k = 1; k < D; k++) begin
                vld_d[k] = vld_q[k-1];
                tag_d[k] = tag_q[k-1];
            end
        end

        // Only valid bits need reset; data/tag flops are qualified by them.
        always_ff @(posedge ap_clk) begin
            if (ap_rst) vld_q <= '0;
            else        vld_q <= vld_d;
            tag_q <= tag_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end

        assign mult = mul(a_q, b_q);

        if (D == 1) begin : g_prod_direct
            assign fin_prod = mult;
        end else begin : g_prod_pipe
            logic [dout_WIDTH-1:0] prod_q [D-1];
            logic [dout_WIDTH-1:0] prod_d [D-1];

            always_comb begin
                prod_d[0] = mult;
                for (int k = 1; k < D - 1; k++) prod_d[k] = prod_q[k-1];
            end

            always_ff @(posedge ap_clk) prod_q <= prod_d;

            assign fin_prod = prod_q[D-2];
        end

        assign fin_vld = vld_q[D-1];
        assign fin_tag = tag_q[D-1];
        assign busy    = |vld_q;
    end

    always_comb begin
        rsp_vld_d  = '0;
        rsp_dout_d = rsp_dout_q;
        if (fin_vld) begin
            rsp_vld_d[fin_tag] = 1'b1;
            rsp_dout_d[int'(fin_tag)*dout_WIDTH +: dout_WIDTH] = fin_prod;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rsp_vld_q  <= '0;
            rsp_dout_q <= '0;
        end else begin
            rsp_vld_q  <= rsp_vld_d;
            rsp_dout_q <= rsp_dout_d;
        end
    end

    assign rsp_vld  = rsp_vld_q;
    assign rsp_dout = rsp_dout_q;

endmodule

// File: tb/tb_conv_5_mul_share_arb.sv
// tb/tb_conv_5_mul_share_arb.sv - directed self-checking bench for conv_5_mul_share_arb
module tb_conv_5_mul_share_arb;
    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        arb_en;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_din0;
    logic [31:0] req_din1;
    logic [3:0]  rsp_vld;
    logic [95:0] rsp_dout;
    logic        busy;

    int checks = 0;
    int errors = 0;

    conv_5_mul_share_arb #(
        .N_REQ(4), .NUM_STAGE(2), .din0_WIDTH(16), .din1_WIDTH(8), .dout_WIDTH(24)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .arb_en(arb_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_din0(req_din0), .req_din1(req_din1),
        .rsp_vld(rsp_vld), .rsp_dout(rsp_dout), .busy(busy)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        logic [31:0] av;
        logic [31:0] bv;
        av = a;
        bv = b;
        req_din0[i*16 +: 16] = av[15:0];
        req_din1[i*8 +: 8]   = bv[7:0];
    endtask

    function automatic logic [23:0] sl(input int i);
        return rsp_dout[i*24 +: 24];
    endfunction

    logic [23:0] exp_p [4];
    logic [3:0]  onehot;

    initial begin
        ap_rst    = 1'b1;
        arb_en    = 1'b1;
        req_valid = 4'b1111;
        req_din0  = '0;
        req_din1  = '0;
        exp_p     = '{24'd30, 24'd100, 24'd2100, 24'd36000};

        // Reset state
        tick();
        tick();
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_rsp_vld", rsp_vld, 4'b0000);
        chk("rst_rsp_dout", rsp_dout, 96'd0);
        chk("rst_busy", busy, 1'b0);
        ap_rst    = 1'b0;
        req_valid = 4'b0000;

        // Single op on requester 1
        set_op(1, 100, -3);
        req_valid = 4'b0010;
        #1 chk("t1_ready", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0000;
        #1 chk("t1_busy", busy, 1'b1);
        chk("t1_vld_early", rsp_vld, 4'b0000);
        tick();
        chk("t1_vld", rsp_vld, 4'b0010);
        chk("t1_dout", sl(1), 24'hFFFED4);
        chk("t1_busy_low", busy, 1'b0);
        tick();
        chk("t1_vld_pulse", rsp_vld, 4'b0000);

        // All four valid continuously from reset
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        set_op(0, 10, 3);
        set_op(1, -20, -5);
        set_op(2, 300, 7);
        set_op(3, -4000, -9);
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            onehot = 4'b0001 << (c % 4);
            chk($sformatf("t2_ready_c%0d", c), req_ready, (c < 8) ? onehot : 4'b0000);
            if (c >= 2) begin
                onehot = 4'b0001 << ((c - 2) % 4);
                chk($sformatf("t2_vld_c%0d", c), rsp_vld, onehot);
                chk($sformatf("t2_dout_c%0d", c), sl((c - 2) % 4), exp_p[(c - 2) % 4]);
            end else begin
                chk($sformatf("t2_vld_c%0d", c), rsp_vld, 4'b0000);
            end
            if (c == 9) chk("t2_busy_drained", busy, 1'b0);
            tick();
        end

        // Fairness: after a grant to 2, requester 3 wins over 0
        req_valid = 4'b0100;
        #1 chk("t3_ready_2", req_ready, 4'b0100);
        tick();
        req_valid = 4'b1001;
        #1 chk("t3_ready_3", req_ready, 4'b1000);
        tick();
        req_valid = 4'b0001;
        #1 chk("t3_ready_0", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0000;
        tick();
        tick();

        // Extreme operands on requesters 1..3 (rr_ptr is 1)
        set_op(1, -32768, -128);
        set_op(2, 32767, 127);
        set_op(3, -32768, 127);
        req_valid = 4'b1110;
        #1 chk("t4_ready_1", req_ready, 4'b0010);
        tick();
        chk("t4_ready_2", req_ready, 4'b0100);
        tick();
        chk("t4_ready_3", req_ready, 4'b1000);
        chk("t4_vld_1", rsp_vld, 4'b0010);
        chk("t4_dout_1", sl(1), 24'h400000);
        tick();
        req_valid = 4'b0000;
        #1 chk("t4_vld_2", rsp_vld, 4'b0100);
        chk("t4_dout_2", sl(2), 24'h3F7F81);
        chk("t4_hold_1", sl(1), 24'h400000);
        tick();
        chk("t4_vld_3", rsp_vld, 4'b1000);
        chk("t4_dout_3", sl(3), 24'hC08000);
        chk("t4_hold_2", sl(2), 24'h3F7F81);
        tick();

        // arb_en low with requests pending (rr_ptr is 0)
        set_op(0, 7, 6);
        req_valid = 4'b0001;
        #1 chk("t5_ready_0", req_ready, 4'b0001);
        tick();
        arb_en    = 1'b0;
        req_valid = 4'b0110;
        #1 chk("t5_ready_off", req_ready, 4'b0000);
        chk("t5_busy_hi", busy, 1'b1);
        tick();
        chk("t5_ready_off2", req_ready, 4'b0000);
        chk("t5_busy_lo", busy, 1'b0);
        chk("t5_vld_0", rsp_vld, 4'b0001);
        chk("t5_dout_0", sl(0), 24'd42);
        tick();
        arb_en = 1'b1;
        #1 chk("t5_ready_resume", req_ready, 4'b0010);
        tick();

        // Reset mid-operation (rr_ptr is 2): grants to 2 and 3, then reset
        req_valid = 4'b1111;
        #1 chk("t6_ready_2", req_ready, 4'b0100);
        tick();
        chk("t6_ready_3", req_ready, 4'b1000);
        tick();
        ap_rst = 1'b1;
        #1 chk("t6_ready_rst", req_ready, 4'b0000);
        tick();
        ap_rst    = 1'b0;
        req_valid = 4'b1010;
        #1 chk("t6_vld_none", rsp_vld, 4'b0000);
        chk("t6_dout_zero", rsp_dout, 96'd0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_ready_low", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0000;
        #1 chk("t6_vld_none2", rsp_vld, 4'b0000);
        tick();
        chk("t6_vld_new", rsp_vld, 4'b0010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
